// File: rtl/rx_buf_pkg.sv
// Shared depth and state naming for both ends of the two-entry receive holding buffer.
// The upstream load counter imports this too, so both sides agree on what "full" means.
package rx_buf_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_t;

    // Push and pop together leave occupancy unchanged; callers only pass accepted events.
    function automatic buf_state_t next_state(buf_state_t cur, logic push, logic pop);
        buf_state_t nxt;
        nxt = cur;
        case (cur)
            BUF_EMPTY: if (push) nxt = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      nxt = BUF_FULL;
                else if (pop && !push) nxt = BUF_EMPTY;
            end
            BUF_FULL: if (pop && !push) nxt = BUF_ONE;
            default: nxt = BUF_EMPTY;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] occ_of(buf_state_t s);
        logic [1:0] occ;
        case (s)
            BUF_ONE:  occ = 2'd1;
            BUF_FULL: occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/hold_buf_reader_if.sv
// Push/pop and status bundle between the upstream loader, the consumer and the holding buffer.
// The slave side is the buffer; master is whoever drives load/pop/flush.
interface hold_buf_reader_if #(
    parameter int DATA_W = 8
);
    logic              flush;
    logic              load_buf;
    logic [DATA_W-1:0] load_data;
    logic              get_data;
    logic [DATA_W-1:0] rx_data;
    logic              data_ready;
    logic              buf_full;
    logic [1:0]        buf_occ;
    logic              overrun;
    logic              underrun;

    modport slave (
        input  flush, load_buf, load_data, get_data,
        output rx_data, data_ready, buf_full, buf_occ, overrun, underrun
    );

    modport master (
        output flush, load_buf, load_data, get_data,
        input  rx_data, data_ready, buf_full, buf_occ, overrun, underrun
    );
endinterface

// File: rtl/hold_buf_reader.sv
// Two-entry oldest-first byte holding buffer; pushed word visible one cycle later, pops every cycle.
// Full drops pushes (sticky overrun) unless a pop lands the same cycle; empty pops flag underrun.
module hold_buf_reader
    import rx_buf_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    hold_buf_reader_if.slave    bus
);

    buf_state_t        state;
    buf_state_t        nxt_state;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [DATA_W-1:0] slot [BUF_DEPTH];
    logic              pop_ok;
    logic              push_ok;
    logic              data_ready_q;
    logic              buf_full_q;
    logic [1:0]        buf_occ_q;
    logic              overrun_q;
    logic              underrun_q;

    // A pop frees the full slot in the same cycle, so a concurrent push is still taken.
    always_comb begin
        pop_ok    = bus.get_data && (state != BUF_EMPTY);
        push_ok   = bus.load_buf && ((state != BUF_FULL) || pop_ok);
        nxt_state = next_state(state, push_ok, pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state        <= BUF_EMPTY;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            data_ready_q <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_occ_q    <= 2'd0;
            if (rst) begin
                for (int i = 0; i < BUF_DEPTH; i++) slot[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= bus.load_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok)                   rd_ptr     <= ~rd_ptr;
            if (bus.load_buf && !push_ok) overrun_q  <= 1'b1;
            if (bus.get_data && !pop_ok)  underrun_q <= 1'b1;
            state        <= nxt_state;
            data_ready_q <= (nxt_state != BUF_EMPTY);
            buf_full_q   <= (nxt_state == BUF_FULL);
            buf_occ_q    <= occ_of(nxt_state);
        end
    end

    assign bus.rx_data    = slot[rd_ptr];
    assign bus.data_ready = data_ready_q;
    assign bus.buf_full   = buf_full_q;
    assign bus.buf_occ    = buf_occ_q;
    assign bus.overrun    = overrun_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_hold_buf_reader.sv
// Drives directed and random push/pop/flush traffic into hold_buf_reader and
// compares every status output against a queue-based occupancy model.
module tb_hold_buf_reader;

    logic clk;
    logic rst;

    hold_buf_reader_if #(.DATA_W(8)) bus ();

    hold_buf_reader #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q [$];
    logic       m_ovr;
    logic       m_unr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check("buf_occ", 32'(bus.buf_occ), 32'(q.size()));
        check("data_ready", 32'(bus.data_ready), 32'(q.size() > 0));
        check("buf_full", 32'(bus.buf_full), 32'(q.size() == 2));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
        check("underrun", 32'(bus.underrun), 32'(m_unr));
        if (q.size() > 0) check("rx_data", 32'(bus.rx_data), 32'(q[0]));
    endtask

    // One clock: apply inputs, advance the model across the edge, then compare.
    task automatic step(input logic r, input logic f, input logic ld,
                        input logic [7:0] d, input logic gd);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        rst           = r;
        bus.flush     = f;
        bus.load_buf  = ld;
        bus.load_data = d;
        bus.get_data  = gd;
        @(posedge clk);
        if (r || f) begin
            q.delete();
            m_ovr = 1'b0;
            m_unr = 1'b0;
        end else begin
            pop_ok  = gd && (q.size() > 0);
            push_ok = ld && ((q.size() < 2) || pop_ok);
            if (gd && !pop_ok) m_unr = 1'b1;
            if (ld && !push_ok) m_ovr = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        #1;
        check_state();
    endtask

    task automatic push(input logic [7:0] d);  step(0, 0, 1, d, 0);  endtask
    task automatic pop();                       step(0, 0, 0, 8'h00, 1); endtask
    task automatic idle();                      step(0, 0, 0, 8'h00, 0); endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.load_buf  = 1'b0;
        bus.load_data = 8'h00;
        bus.get_data  = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_unr = 1'b0;

        // Reset, then idle: everything reads zero including the cleared slot.
        step(1, 0, 0, 8'h00, 0);
        check("rx_data_reset", 32'(bus.rx_data), 32'h0);
        for (int i = 0; i < 3; i++) idle();
        pop();

        // Fill, drain in order.
        step(1, 0, 0, 8'h00, 0);
        push(8'hA5);
        push(8'h3C);
        pop();
        pop();

        // Third push while full is dropped; the two held words still come out in order.
        push(8'hA5);
        push(8'h3C);
        push(8'h77);
        pop();
        pop();
        idle();

        // Full-throughput push+pop while full, across pointer wrap.
        push(8'hA5);
        push(8'h3C);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h11 + i), 1);
        pop();
        pop();

        // Flush while full with both strobes high: strobes ignored, flags cleared.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        pop();
        pop();
        pop();
        push(8'h04);
        push(8'h05);
        step(0, 1, 1, 8'hEE, 1);
        push(8'h5A);

        // Empty pop with concurrent push: flagged, yet the push lands.
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 1, 8'hC3, 1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 49) == 0);
            step(r, f, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
